// File: rtl/stair_scheduler_if.sv
// stair_scheduler_if: go/config inputs and VGA pixel-port outputs of the stair scheduler.
// Build option: STAIR_COLOUR_EN adds cfg_colour (per-stair draw colour).
// master drives go/cfg_*; slave (the scheduler) drives cfg_ready, x, y, colour, plot, busy, current_state.
interface stair_scheduler_if;
  logic go, cfg_we, cfg_en, cfg_ready, plot, busy;
  logic [2:0] cfg_idx, colour, current_state;
  logic [7:0] cfg_x, x;
  logic [6:0] cfg_y, y;
`ifdef STAIR_COLOUR_EN
  logic [2:0] cfg_colour;
  modport master(output go, cfg_we, cfg_idx, cfg_x, cfg_y, cfg_en, cfg_colour,
                 input cfg_ready, x, y, colour, plot, busy, current_state);
  modport slave(input go, cfg_we, cfg_idx, cfg_x, cfg_y, cfg_en, cfg_colour,
                output cfg_ready, x, y, colour, plot, busy, current_state);
`else
  modport master(output go, cfg_we, cfg_idx, cfg_x, cfg_y, cfg_en,
                 input cfg_ready, x, y, colour, plot, busy, current_state);
  modport slave(input go, cfg_we, cfg_idx, cfg_x, cfg_y, cfg_en,
                output cfg_ready, x, y, colour, plot, busy, current_state);
`endif
endinterface

// File: rtl/stair_scheduler.sv
// stair_scheduler: draws, waits, erases and scrolls NUM_STAIRS stair sprites through one VGA pixel port.
// Ports: clock, reset (async, active-high); bus (stair_scheduler_if.slave) carrying go, cfg_* writes,
// cfg_ready/busy/current_state status and the registered x/y/colour/plot pixel outputs.
// Build option: STAIR_COLOUR_EN gives each stair its own draw colour via cfg_colour.
module stair_scheduler #(
  parameter int NUM_STAIRS = 4,
  parameter int STAIR_W = 40,
  parameter int STAIR_H = 5,
  parameter int FRAME_TICKS = 833334,
  parameter int Y_WRAP = 116,
  parameter int INIT_X = 60,
  parameter int INIT_Y0 = 40,
  parameter int INIT_DY = 30,
  parameter logic [2:0] DRAW_COLOUR = 3'b100
) (
  input logic clock,
  input logic reset,
  stair_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, DRAW = 3'd1, WAIT = 3'd2, ERASE = 3'd3, UPDATE = 3'd4} state_t;
  state_t state_q;
  logic [7:0] sx_q [8];
  logic [6:0] sy_q [8];
  logic [7:0] en_q;
  logic [2:0] idx_q;
  logic [7:0] px_q;
  logic [6:0] py_q;
  logic [31:0] tick_q;
  logic done_q, go_q, plot_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic wr, hit, emit, cur_en, last_px, last_py, stair_end, last_stair;
  logic [7:0] cur_x;
  logic [6:0] cur_y;
  logic [2:0] cur_col, draw_col;
  function automatic logic [6:0] scroll(input logic [6:0] v);
    return v == 7'd0 ? 7'(Y_WRAP) : v - 7'd1;
  endfunction
  assign wr = bus.cfg_we && state_q == IDLE && {5'd0, bus.cfg_idx} < 8'(NUM_STAIRS);
`ifdef STAIR_COLOUR_EN
  logic [2:0] col_q [8];
  assign draw_col = hit ? bus.cfg_colour : col_q[idx_q];
  always_ff @(posedge clock or posedge reset)
    if (reset)
      for (int i = 0; i < 8; i++) col_q[i] <= DRAW_COLOUR;
    else if (wr)
      col_q[bus.cfg_idx] <= bus.cfg_colour;
`else
  assign draw_col = DRAW_COLOUR;
`endif
  // Outputs are registered, so the pixel is formed from the stair it will belong to: a write
  // landing with go in IDLE and the scroll applied in UPDATE are forwarded into the first pixel.
  always_comb begin
    hit = wr && bus.cfg_idx == idx_q;
    cur_x = hit ? bus.cfg_x : sx_q[idx_q];
    cur_y = hit ? bus.cfg_y : state_q == UPDATE ? scroll(sy_q[idx_q]) : sy_q[idx_q];
    cur_en = hit ? bus.cfg_en : en_q[idx_q];
    cur_col = (state_q == WAIT || state_q == ERASE) ? 3'b000 : draw_col;
    last_px = px_q == 8'(STAIR_W - 1);
    last_py = py_q == 7'(STAIR_H - 1);
    stair_end = !cur_en || (last_px && last_py);
    last_stair = idx_q == 3'(NUM_STAIRS - 1);
    emit = (state_q == IDLE && bus.go) || ((state_q == DRAW || state_q == ERASE) && !done_q) ||
           (state_q == WAIT && tick_q == 32'(FRAME_TICKS - 1)) || state_q == UPDATE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      px_q <= '0;
      py_q <= '0;
      tick_q <= '0;
      done_q <= 1'b0;
      go_q <= 1'b0;
      plot_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= '0;
      for (int i = 0; i < 8; i++) begin
        sx_q[i] <= 8'(INIT_X);
        sy_q[i] <= 7'((INIT_Y0 + i * INIT_DY) % 128);
        en_q[i] <= i < NUM_STAIRS;
      end
    end else begin
      plot_q <= 1'b0;
      if (wr) begin
        sx_q[bus.cfg_idx] <= bus.cfg_x;
        sy_q[bus.cfg_idx] <= bus.cfg_y;
        en_q[bus.cfg_idx] <= bus.cfg_en;
      end
      // A disabled stair consumes one silent step; done_q marks the pass as fully emitted.
      if (emit) begin
        plot_q <= cur_en;
        x_q <= cur_x + px_q;
        y_q <= cur_y + py_q;
        colour_q <= cur_col;
        px_q <= (stair_end || last_px) ? '0 : px_q + 8'd1;
        py_q <= stair_end ? '0 : last_px ? py_q + 7'd1 : py_q;
        idx_q <= stair_end ? (last_stair ? '0 : idx_q + 3'd1) : idx_q;
        done_q <= stair_end && last_stair;
      end
      case (state_q)
        IDLE: if (bus.go) state_q <= DRAW;
        DRAW:
          if (done_q) begin
            state_q <= WAIT;
            tick_q <= '0;
            done_q <= 1'b0;
          end
        WAIT:
          if (emit) begin
            state_q <= ERASE;
            go_q <= bus.go;
          end else tick_q <= tick_q + 32'd1;
        ERASE:
          if (done_q) begin
            state_q <= go_q ? UPDATE : IDLE;
            done_q <= 1'b0;
          end
        UPDATE: begin
          state_q <= DRAW;
          for (int i = 0; i < 8; i++) sy_q[i] <= scroll(sy_q[i]);
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.x = x_q;
  assign bus.y = y_q;
  assign bus.colour = colour_q;
  assign bus.plot = plot_q;
  assign bus.busy = state_q != IDLE;
  assign bus.cfg_ready = state_q == IDLE;
  assign bus.current_state = state_q;
endmodule

// File: tb/tb_stair_scheduler.sv
// tb_stair_scheduler: randomized scenario tests of stair_scheduler against a per-stair pixel-list model.
module tb_stair_scheduler;
  localparam int NS = 4, W = 40, H = 5, FT = 5, YW = 116;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  stair_scheduler_if bus();
  stair_scheduler #(.FRAME_TICKS(FT)) dut(.clock(clk), .reset(rst), .bus(bus));
  int passed = 0, total = 0;
  logic [7:0] mx [NS];
  logic [6:0] my [NS];
  logic men [NS];
  logic [2:0] mcol [NS];
  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      mx[i] = 8'd60;
      my[i] = 7'((40 + 30 * i) % 128);
      men[i] = 1'b1;
      mcol[i] = 3'b100;
    end
  endtask
  task automatic cfg_write(input logic [2:0] idx, input logic [7:0] xv, input logic [6:0] yv, input logic en, input logic g);
    bus.cfg_we = 1'b1;
    bus.cfg_idx = idx;
    bus.cfg_x = xv;
    bus.cfg_y = yv;
    bus.cfg_en = en;
    bus.go = g;
`ifdef STAIR_COLOUR_EN
    bus.cfg_colour = 3'($urandom);
    if (idx < NS) mcol[idx] = bus.cfg_colour;
`endif
    if (idx < NS) begin
      mx[idx] = xv;
      my[idx] = yv;
      men[idx] = en;
    end
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask
  task automatic start();
    bus.go = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_reset();
    total++;
    if ({bus.plot, bus.x, bus.y, bus.colour} !== 19'd0) $display("FAIL reset_pixel: got %h want 0", {bus.plot, bus.x, bus.y, bus.colour});
    else passed++;
    total++;
    if ({bus.busy, bus.cfg_ready} !== 2'b01) $display("FAIL reset_status: got busy=%b ready=%b want 0/1", bus.busy, bus.cfg_ready);
    else passed++;
    total++;
    if (bus.current_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", bus.current_state);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_pass(input bit erase, input bit poke, output int plots, output int cycles);
    plots = 0;
    cycles = 0;
    for (int i = 0; i < NS; i++)
      for (int k = 0; k < (men[i] ? W * H : 1); k++) begin
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec, es;
        ex = mx[i] + 8'(k % W);
        ey = my[i] + 7'(k / W);
        ec = erase ? 3'b000 : mcol[i];
        es = erase ? 3'd3 : 3'd1;
        total++;
        if (bus.current_state !== es || bus.cfg_ready !== 1'b0 || bus.plot !== men[i] ||
            (men[i] && {bus.x, bus.y, bus.colour} !== {ex, ey, ec}))
          $display("FAIL %s s%0d p%0d: got st=%0d plot=%b (%0d,%0d) c=%b want st=%0d plot=%b (%0d,%0d) c=%b",
                   erase ? "erase" : "draw", i, k, bus.current_state, bus.plot, bus.x, bus.y, bus.colour,
                   es, men[i], ex, ey, ec);
        else passed++;
        plots += int'(bus.plot);
        cycles++;
        bus.go = 1'($urandom);
        if (poke && cycles == 10) begin
          bus.cfg_we = 1'b1;
          bus.cfg_idx = 3'd0;
          bus.cfg_x = 8'd1;
          bus.cfg_y = 7'd5;
          bus.cfg_en = 1'b0;
        end
        @(negedge clk);
        bus.cfg_we = 1'b0;
      end
  endtask
  task automatic test_wait(input bit g);
    for (int c = 0; c < FT; c++) begin
      total++;
      if (bus.current_state !== 3'd2 || bus.plot !== 1'b0) $display("FAIL wait c%0d: got st=%0d plot=%b want st=2 plot=0", c, bus.current_state, bus.plot);
      else passed++;
      bus.go = (c == FT - 1) ? g : !g;
      @(negedge clk);
    end
  endtask
  task automatic run_frame(input bit g, input bit poke, output int plots, output int cycles);
    int ep, ec;
    test_pass(1'b0, 1'b0, plots, cycles);
    test_wait(g);
    test_pass(1'b1, poke, ep, ec);
    total++;
    if (ep !== plots) $display("FAIL erase_count: got %0d want %0d", ep, plots);
    else passed++;
    total++;
    if (g) begin
      if (bus.current_state !== 3'd4 || bus.plot !== 1'b0) $display("FAIL update: got st=%0d plot=%b want st=4 plot=0", bus.current_state, bus.plot);
      else passed++;
      for (int i = 0; i < NS; i++) my[i] = my[i] == 7'd0 ? 7'(YW) : my[i] - 7'd1;
      @(negedge clk);
    end else begin
      bus.go = 1'b0;
      if (bus.current_state !== 3'd0 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1 || bus.plot !== 1'b0)
        $display("FAIL idle: got st=%0d busy=%b ready=%b plot=%b want 0/0/1/0", bus.current_state, bus.busy, bus.cfg_ready, bus.plot);
      else passed++;
    end
  endtask
  task automatic test_draw_erase();
    int p, c;
    start();
    run_frame(1'b1, 1'b0, p, c);
    total++;
    if (p !== 800 || c !== 800) $display("FAIL full_pass: got plots=%0d cycles=%0d want 800/800", p, c);
    else passed++;
    run_frame(1'b0, 1'b0, p, c);
  endtask
  task automatic test_wrap();
    int p, c;
    cfg_write(3'd0, mx[0], 7'd0, 1'b1, 1'b0);
    start();
    run_frame(1'b1, 1'b0, p, c);
    total++;
    if (my[0] !== 7'(YW)) $display("FAIL wrap_model: got %0d want %0d", my[0], YW);
    else passed++;
    run_frame(1'b0, 1'b0, p, c);
  endtask
  task automatic test_disable();
    int p, c;
    cfg_write(3'd2, mx[2], my[2], 1'b0, 1'b0);
    start();
    run_frame(1'b0, 1'b0, p, c);
    total++;
    if (p !== 600 || c !== 601) $display("FAIL disabled_pass: got plots=%0d cycles=%0d want 600/601", p, c);
    else passed++;
    cfg_write(3'd2, mx[2], my[2], 1'b1, 1'b0);
  endtask
  task automatic test_stop();
    int p, c;
    start();
    run_frame(1'b0, 1'b1, p, c);
    start();
    run_frame(1'b0, 1'b0, p, c);
  endtask
  task automatic test_async_reset();
    int p, c;
    start();
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    bus.go = 1'b0;
    #1;
    total++;
    if (bus.plot !== 1'b0 || bus.current_state !== 3'd0) $display("FAIL async_reset: got plot=%b st=%0d want 0/0", bus.plot, bus.current_state);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    start();
    run_frame(1'b0, 1'b0, p, c);
  endtask
  task automatic test_random();
    int p, c;
    for (int r = 0; r < 4; r++) begin
      repeat (3) cfg_write(3'($urandom_range(0, 7)), 8'($urandom), 7'($urandom), $urandom_range(0, 3) != 0, 1'b0);
      cfg_write(3'($urandom_range(0, NS - 1)), 8'($urandom), 7'($urandom), 1'b1, 1'b1);
      run_frame(1'b1, 1'b0, p, c);
      run_frame(1'b0, 1'b0, p, c);
    end
  endtask
  initial begin
    bus.go = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_idx = 3'd0;
    bus.cfg_x = 8'd0;
    bus.cfg_y = 7'd0;
    bus.cfg_en = 1'b0;
`ifdef STAIR_COLOUR_EN
    bus.cfg_colour = 3'd0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_draw_erase();
    test_wrap();
    test_disable();
    test_stop();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
